mult_signed_seq: RTL and testbench

//  Parametrised iterative N x N multiplier with selectable signed or unsigned operands.

---
 rtl/mult_signed_seq.sv | 126 ++++++++++++
 tb/tb_mult_signed_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_signed_seq.sv
// Iterative N x N multiplier, signed or unsigned, reducing RPC partial-product rows per cycle
// into a 2N-bit accumulator under a start/done handshake.
module mult_signed_seq #(
  parameter int N   = 4,
  parameter int RPC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(N + 1);

  if (N < 2 || !(RPC == 1 || RPC == 2 || RPC == 4) || (N % RPC) != 0) begin : g_bad_params
    $error("mult_signed_seq: need N >= 2, RPC in {1,2,4} and N %% RPC == 0");
  end

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    ext_a;
  logic [W-1:0]    row;
  logic [W-1:0]    acc_sum;
  logic [CW-1:0]   idx;
  logic [CW-1:0]   cnt_nxt;

  always_comb begin
    ext_a   = sgn_q ? {{N{a_q[N-1]}}, a_q} : {{N{1'b0}}, a_q};
    acc_sum = acc_q;
    row     = '0;
    idx     = cnt_q;
    for (int j = 0; j < RPC; j++) begin
      idx = cnt_q + CW'(j);
      row = (|(b_q & (N'(1) << idx))) ? (ext_a << idx) : '0;
      // The MSB of a signed multiplier carries weight -2^(N-1), so its row is negated.
      if (sgn_q && idx == CW'(N - 1)) acc_sum = acc_sum + (~row + W'(1));
      else                            acc_sum = acc_sum + row;
    end
    cnt_nxt = cnt_q + CW'(RPC);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_mode;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_sum;
        cnt_d = cnt_nxt;
        if (cnt_nxt == CW'(N)) begin
          product_d = acc_sum;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_signed_seq.sv
// Directed bench for mult_signed_seq: three N=4 instances with RPC = 1, 2, 4,
// hand-computed vectors plus an exhaustive sweep against a behavioural a*b model.
module tb_mult_signed_seq;
  localparam int N = 4;

  logic             clk;
  logic             rst_n;
  logic [2:0]       start_v;
  logic             signed_mode;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [2:0]       busy_v;
  logic [2:0]       done_v;
  logic [2*N-1:0]   prod_v [3];

  int n_vec;
  int n_err;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mult_signed_seq #(.N(N), .RPC(1 << g)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_v[g]),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .product     (prod_v[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic s, input logic [3:0] x, input logic [3:0] y);
    int p;
    logic [31:0] pv;
    if (s) p = int'($signed(x)) * int'($signed(y));
    else   p = int'(x) * int'(y);
    pv = p;
    return pv[7:0];
  endfunction

  // Called just after the accepting edge; returns cycles until done and busy-high samples.
  task automatic wait_done(input int g, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done_v[g] && lat < 40) begin
      if (busy_v[g]) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input int g, input logic s, input logic [3:0] x, input logic [3:0] y,
                       input string tag);
    int lat;
    int bcnt;
    start_v[g]  = 1'b1;
    signed_mode = s;
    a           = x;
    b           = y;
    tick();
    start_v[g]  = 1'b0;
    wait_done(g, lat, bcnt);
    check({tag, "_latency"}, lat + 1, (N >> g) + 1);
    check({tag, "_product"}, prod_v[g], model(s, x, y));
    tick();
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    start_v     = '0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    #13;
    check("reset_busy", busy_v[0], 0);
    check("reset_done", done_v[0], 0);
    check("reset_product", prod_v[0], 8'h00);
    rst_n = 1'b1;
    tick();

    // -8 * -8 signed: the corner where the negated MSB row matters most
    start_v[0]  = 1'b1;
    signed_mode = 1'b1;
    a           = 4'h8;
    b           = 4'h8;
    tick();
    start_v[0]  = 1'b0;
    wait_done(0, lat, bcnt);
    check("t1_done_cycles", lat + 1, 5);
    check("t1_busy_cycles", bcnt, 4);
    check("t1_product", prod_v[0], 8'h40);
    check("t1_busy_at_done", busy_v[0], 0);
    tick();
    check("t1_done_pulse", done_v[0], 0);
    check("t1_product_hold", prod_v[0], 8'h40);

    // Signed and unsigned directed vectors with literal expectations
    start_v[0] = 1'b1; signed_mode = 1'b1; a = 4'h7; b = 4'h8;
    tick(); start_v[0] = 1'b0; wait_done(0, lat, bcnt);
    check("t2_7x8", prod_v[0], 8'hC8);
    tick();
    start_v[0] = 1'b1; signed_mode = 1'b1; a = 4'hF; b = 4'h1;
    tick(); start_v[0] = 1'b0; wait_done(0, lat, bcnt);
    check("t2_m1x1", prod_v[0], 8'hFF);
    tick();
    start_v[0] = 1'b1; signed_mode = 1'b0; a = 4'hF; b = 4'hF;
    tick(); start_v[0] = 1'b0; wait_done(0, lat, bcnt);
    check("t3_u15x15", prod_v[0], 8'hE1);
    tick();
    start_v[0] = 1'b1; signed_mode = 1'b1; a = 4'hF; b = 4'hF;
    tick(); start_v[0] = 1'b0; wait_done(0, lat, bcnt);
    check("t3_sm1xm1", prod_v[0], 8'h01);
    tick();

    // start held high; operands change while busy and must be ignored
    start_v[0] = 1'b1; signed_mode = 1'b1; a = 4'h7; b = 4'h8;
    tick();
    a = 4'h3; b = 4'h5;
    wait_done(0, lat, bcnt);
    check("t4_held_latency", lat + 1, 5);
    check("t4_held_product", prod_v[0], 8'hC8);
    tick();
    check("t4_idle_busy", busy_v[0], 0);
    a = 4'hF; b = 4'h1;
    tick();
    start_v[0] = 1'b0;
    check("t4_reaccept_busy", busy_v[0], 1);
    wait_done(0, lat, bcnt);
    check("t4_second_latency", lat + 1, 5);
    check("t4_second_product", prod_v[0], 8'hFF);
    tick();

    // Reset pulsed mid-accumulation aborts the operation
    start_v[0] = 1'b1; signed_mode = 1'b0; a = 4'h6; b = 4'h5;
    tick();
    start_v[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy_v[0], 0);
    check("t5_rst_done", done_v[0], 0);
    check("t5_rst_product", prod_v[0], 8'h00);
    #2;
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_v[0]) dcnt++;
    end
    check("t5_no_done_after_abort", dcnt, 0);
    do_op(0, 1'b0, 4'h6, 4'h5, "t5_recover");

    // Exhaustive sweep on every RPC instance, both modes
    for (int g = 0; g < 3; g++) begin
      for (int s = 0; s < 2; s++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            do_op(g, s[0], x[3:0], y[3:0], $sformatf("ex_rpc%0d_s%0d_%0h_%0h", 1 << g, s, x, y));
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
